ctrl_dq_bus_scheduler: RTL
==========================

# ctrl_dq_bus_scheduler

Arbitrates column (CAS) read and write requests from the controller command path onto the shared DQ/DQS data bus. It grants at most one request per cycle, and only when the resulting data burst cannot collide with bursts already scheduled. Each granted request is delayed by CL (read) or CWL (write) cycles. It is then released as a one-cycle `rd_start` or `wr_start` pulse with its burst length and preamble, which the read-data and write-data drivers consume.

## Interface
- `CL`, 16: read latency in CK cycles, grant to `rd_start`; legal range 8..31.
- `CWL`, 12: write latency in CK cycles, grant to `wr_start`; legal range 8..31.
- `TURN_R2W`, 2: extra idle bus cycles required between the end of a read burst and the next write burst.
- `TURN_W2R`, 4: extra idle bus cycles required between the end of a write burst and the next read burst.
- `CK_t`  in  1  controller clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rd_req`  in  1  read request valid; held until `rd_gnt`.
- `rd_bc4`  in  1  with `rd_req`: 1 = BC4 (4 beats), 0 = BL8 (8 beats).
- `rd_pre2`  in  1  with `rd_req`: 1 = 2-cycle preamble, 0 = 1-cycle preamble.
- `wr_req`, `wr_bc4`, `wr_pre2`  in  1 each  write equivalents.
- `rd_gnt`  out  1  read accepted this cycle (combinational from request and state).
- `wr_gnt`  out  1  write accepted this cycle; never high together with `rd_gnt`.
- `rd_start`  out  1  one-cycle pulse: read data phase (preamble) begins.
- `rd_bl`  out  4  with `rd_start`: 4 or 8.
- `rd_pre`  out  2  with `rd_start`: 1 or 2.
- `wr_start`, `wr_bl`, `wr_pre`  out  1/4/2  write equivalents.

## Operation
- Burst occupancy O = pre + beats/2 + 1 (postamble) cycles:
  - BL8, pre 1 → 6.
  - BC4, pre 2 → 5.
- State:
  - `busy` (6-bit): the bus is free from cycle now+`busy` onward.
  - `last_dir`: direction of the last grant (RD/WR).
  - `last_gnt`: arbitration history.
  - Read delay pipeline: CL stages of {valid, bc4, pre2}.
  - Write delay pipeline: CWL stages of {valid, bc4, pre2}.
- Eligibility:
  - Read: `rd_req` && CL >= `busy` + (`last_dir`==WR ? TURN_W2R : 0).
  - Write: `wr_req` && CWL >= `busy` + (`last_dir`==RD ? TURN_R2W : 0).
- Arbitration:
  - One eligible request is granted.
  - Both eligible: grant the direction opposite to `last_gnt` (round-robin).
- On a grant with latency L and occupancy O: `busy` <= L+O-1; `last_dir` and `last_gnt` <= granted direction.
- No grant: `busy` <= `busy`==0 ? 0 : `busy`-1 (saturating).
- Granted attributes enter stage 0 of the matching pipeline. The pipeline shifts every cycle. Stage output drives `*_start`, `*_bl` (bc4 ? 4 : 8) and `*_pre` (pre2 ? 2 : 1).
- `*_bl` and `*_pre` are 0 whenever `*_start` is 0.
- Bursts leave in grant order per direction. The eligibility rule guarantees that read and write start windows never overlap.
- The turnaround penalty applies even when `busy`==0. This is harmless because CL and CWL exceed both TURN values.
- Requests must stay stable while waiting. A request dropped before grant is simply not granted; nothing is stored.

## Timing
- Reset values: `busy`=0, `last_dir`=RD, `last_gnt`=WR, all pipelines invalid, all outputs 0.
- First request after reset is grantable in the same cycle.
- Grant at cycle t → `*_start` high in exactly cycle t+L, for one cycle.
- Same-direction back-to-back at full rate: start-to-start spacing = O of the first burst.
- Reset asserted mid-operation:
  - Clears all pipelines immediately.
  - No `*_start` pulse for any pre-reset grant, during or after reset.
- Simultaneous eligibility: the grant goes to the direction not granted last; there is no starvation.

## Test plan
- Single read, BL8 pre1, `rd_req` at cycle 10 → `rd_gnt`@10, `rd_start`@26 with `rd_bl`=8, `rd_pre`=1; `busy`=21 at cycle 11.
- Two reads BL8 pre1, both requests held from t → grants at t and t+6, starts at t+16 and t+22.
- Read at t (BL8 pre1) then `wr_req` held → `wr_gnt` at t+12, `wr_start` at t+24 (read ends t+21, TURN_R2W=2).
- Write at t (BL8 pre1) then `rd_req` held → `rd_gnt` at t+6, `rd_start` at t+22; BC4 pre2 variant outputs `bl`=4, `pre`=2.
- `rd_req` and `wr_req` both high from an idle bus with `last_gnt`=WR:
  - Read granted first, then the write at the first eligible cycle.
  - No start windows overlap.
- Three reads granted, `reset_n` pulsed low 5 cycles after the first grant → no `rd_start` thereafter; all outputs 0; a new read grants immediately after release.

Source files
------------

// File: rtl/ctrl_dq_bus_scheduler_if.sv
// DQ bus scheduler request/grant/start bundle.
// master: command path + data drivers; slave: scheduler.
interface ctrl_dq_bus_scheduler_if;
  logic       rd_req;
  logic       rd_bc4;
  logic       rd_pre2;
  logic       wr_req;
  logic       wr_bc4;
  logic       wr_pre2;
  logic       rd_gnt;
  logic       wr_gnt;
  logic       rd_start;
  logic [3:0] rd_bl;
  logic [1:0] rd_pre;
  logic       wr_start;
  logic [3:0] wr_bl;
  logic [1:0] wr_pre;

  modport master (
    output rd_req, rd_bc4, rd_pre2,
    output wr_req, wr_bc4, wr_pre2,
    input  rd_gnt, wr_gnt,
    input  rd_start, rd_bl, rd_pre,
    input  wr_start, wr_bl, wr_pre
  );

  modport slave (
    input  rd_req, rd_bc4, rd_pre2,
    input  wr_req, wr_bc4, wr_pre2,
    output rd_gnt, wr_gnt,
    output rd_start, rd_bl, rd_pre,
    output wr_start, wr_bl, wr_pre
  );
endinterface

// File: rtl/ctrl_dq_bus_scheduler.sv
// CAS read/write arbiter for the shared DQ bus; delays grants by CL/CWL.
// Ports: CK_t, reset_n (async low), bus (slave: req/gnt/start bundle).
module ctrl_dq_bus_scheduler #(
  parameter int CL       = 16,
  parameter int CWL      = 12,
  parameter int TURN_R2W = 2,
  parameter int TURN_W2R = 4
) (
  input  logic                     CK_t,
  input  logic                     reset_n,
  ctrl_dq_bus_scheduler_if.slave   bus
);

  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

  typedef struct packed {
    logic vld;
    logic bc4;
    logic pre2;
  } slot_t;

  logic [5:0]      busy_q, busy_d;
  logic            last_dir_q, last_dir_d;
  logic            last_gnt_q, last_gnt_d;
  slot_t [CL-1:0]  rd_pipe_q, rd_pipe_d;
  slot_t [CWL-1:0] wr_pipe_q, wr_pipe_d;

  logic [6:0] rd_need;
  logic [6:0] wr_need;
  logic       rd_elig;
  logic       wr_elig;
  logic       rd_win;
  logic       wr_win;
  slot_t      rd_in;
  slot_t      wr_in;
  slot_t      rd_out;
  slot_t      wr_out;

  // Bus cycles used: preamble + beats/2 + postamble.
  function automatic logic [5:0] occ(
    input logic bc4,
    input logic pre2
  );
    occ = 6'd1
        + (pre2 ? 6'd2 : 6'd1)
        + (bc4  ? 6'd2 : 6'd4);
  endfunction

  always_comb begin
    rd_need = {1'b0, busy_q};
    wr_need = {1'b0, busy_q};
    if (last_dir_q == DIR_WR)
      rd_need = rd_need + 7'(TURN_W2R);
    if (last_dir_q == DIR_RD)
      wr_need = wr_need + 7'(TURN_R2W);
    rd_elig = bus.rd_req && (7'(CL) >= rd_need);
    wr_elig = bus.wr_req && (7'(CWL) >= wr_need);
  end

  // Round-robin only matters when both sides are eligible.
  always_comb begin
    rd_win = 1'b0;
    wr_win = 1'b0;
    unique case ({rd_elig, wr_elig})
      2'b11: begin
        if (last_gnt_q == DIR_WR) rd_win = 1'b1;
        else                      wr_win = 1'b1;
      end
      2'b10:   rd_win = 1'b1;
      2'b01:   wr_win = 1'b1;
      default: ;
    endcase
  end

  assign bus.rd_gnt = rd_win;
  assign bus.wr_gnt = wr_win;

  always_comb begin
    busy_d     = (busy_q == 6'd0) ? 6'd0
                                  : busy_q - 6'd1;
    last_dir_d = last_dir_q;
    last_gnt_d = last_gnt_q;
    if (rd_win) begin
      busy_d     = 6'(CL) - 6'd1
                 + occ(bus.rd_bc4, bus.rd_pre2);
      last_dir_d = DIR_RD;
      last_gnt_d = DIR_RD;
    end else if (wr_win) begin
      busy_d     = 6'(CWL) - 6'd1
                 + occ(bus.wr_bc4, bus.wr_pre2);
      last_dir_d = DIR_WR;
      last_gnt_d = DIR_WR;
    end
  end

  always_comb begin
    rd_in.vld  = rd_win;
    rd_in.bc4  = rd_win & bus.rd_bc4;
    rd_in.pre2 = rd_win & bus.rd_pre2;
    wr_in.vld  = wr_win;
    wr_in.bc4  = wr_win & bus.wr_bc4;
    wr_in.pre2 = wr_win & bus.wr_pre2;
    rd_pipe_d  = {rd_pipe_q[CL-2:0], rd_in};
    wr_pipe_d  = {wr_pipe_q[CWL-2:0], wr_in};
  end

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      busy_q     <= 6'd0;
      last_dir_q <= DIR_RD;
      last_gnt_q <= DIR_WR;
      rd_pipe_q  <= '0;
      wr_pipe_q  <= '0;
    end else begin
      busy_q     <= busy_d;
      last_dir_q <= last_dir_d;
      last_gnt_q <= last_gnt_d;
      rd_pipe_q  <= rd_pipe_d;
      wr_pipe_q  <= wr_pipe_d;
    end
  end

  // Last stage holds the burst starting this cycle.
  assign rd_out = rd_pipe_q[CL-1];
  assign wr_out = wr_pipe_q[CWL-1];

  always_comb begin
    bus.rd_start = rd_out.vld;
    bus.rd_bl    = 4'd0;
    bus.rd_pre   = 2'd0;
    if (rd_out.vld) begin
      bus.rd_bl  = rd_out.bc4  ? 4'd4 : 4'd8;
      bus.rd_pre = rd_out.pre2 ? 2'd2 : 2'd1;
    end
    bus.wr_start = wr_out.vld;
    bus.wr_bl    = 4'd0;
    bus.wr_pre   = 2'd0;
    if (wr_out.vld) begin
      bus.wr_bl  = wr_out.bc4  ? 4'd4 : 4'd8;
      bus.wr_pre = wr_out.pre2 ? 2'd2 : 2'd1;
    end
  end

endmodule
